// File: rtl/alu_secuenciador_if.sv
// Bus between the operand sequencer (master) and the combinational N-bit ALU (slave).
interface alu_secuenciador_if #(
    parameter int N = 3
);
    logic [N-1:0] alu_A;
    logic [N-1:0] alu_B;
    logic [3:0]   alu_select;
    logic         alu_flagin;
    logic [N-1:0] alu_resultado;
    logic         alu_neg;
    logic         alu_zero;
    logic         alu_cout;
    logic         alu_ovf;

    modport master (
        output alu_A, alu_B, alu_select, alu_flagin,
        input  alu_resultado, alu_neg, alu_zero, alu_cout, alu_ovf
    );

    modport slave (
        input  alu_A, alu_B, alu_select, alu_flagin,
        output alu_resultado, alu_neg, alu_zero, alu_cout, alu_ovf
    );
endinterface

// File: rtl/alu_secuenciador.sv
// Loads A, B and op code on button strobes, drives the ALU, latches result/flags and counts operations.
// Define ALU_ACUM_EN for accumulator mode (a strobe in MUESTRA chains the result into operand A).
module alu_secuenciador #(
    parameter int N  = 3,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         dato,
    input  logic [3:0]           sel_in,
    input  logic                 flagin_in,
    input  logic                 cargar,
    alu_secuenciador_if.master   alu,
    output logic [N-1:0]         resultado_reg,
    output logic [3:0]           flags_reg,
    output logic [2:0]           estado,
    output logic                 listo,
    output logic [CW-1:0]        num_ops
);

    typedef enum logic [2:0] {
        CARGA_A  = 3'd0,
        CARGA_B  = 3'd1,
        CARGA_OP = 3'd2,
        EXEC     = 3'd3,
        MUESTRA  = 3'd4
    } estado_t;

    estado_t       state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [3:0]    sel_q, sel_d;
    logic          flagin_q, flagin_d;
    logic [N-1:0]  res_q, res_d;
    logic [3:0]    flags_q, flags_d;
    logic          listo_q, listo_d;
    logic [CW-1:0] num_ops_q, num_ops_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CARGA_A;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= '0;
            flagin_q  <= 1'b0;
            res_q     <= '0;
            flags_q   <= '0;
            listo_q   <= 1'b0;
            num_ops_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_q     <= sel_d;
            flagin_q  <= flagin_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
            listo_q   <= listo_d;
            num_ops_q <= num_ops_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        flagin_d  = flagin_q;
        res_d     = res_q;
        flags_d   = flags_q;
        listo_d   = listo_q;
        num_ops_d = num_ops_q;
        case (state_q)
            CARGA_A: begin
                if (cargar) begin
                    a_d     = dato;
                    state_d = CARGA_B;
                end
            end
            CARGA_B: begin
                if (cargar) begin
                    b_d     = dato;
                    state_d = CARGA_OP;
                end
            end
            CARGA_OP: begin
                if (cargar) begin
                    sel_d    = sel_in;
                    flagin_d = flagin_in;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // Operands have been stable on the ALU for a full cycle; cargar is ignored here.
                res_d     = alu.alu_resultado;
                flags_d   = {alu.alu_neg, alu.alu_zero, alu.alu_cout, alu.alu_ovf};
                listo_d   = 1'b1;
                num_ops_d = num_ops_q + CW'(1);
                state_d   = MUESTRA;
            end
            MUESTRA: begin
                if (cargar) begin
                    listo_d = 1'b0;
`ifdef ALU_ACUM_EN
                    a_d     = res_q;
                    state_d = CARGA_B;
`else
                    state_d = CARGA_A;
`endif
                end
            end
            default: state_d = CARGA_A;
        endcase
    end

    assign alu.alu_A      = a_q;
    assign alu.alu_B      = b_q;
    assign alu.alu_select = sel_q;
    assign alu.alu_flagin = flagin_q;
    assign resultado_reg  = res_q;
    assign flags_reg      = flags_q;
    assign estado         = state_q;
    assign listo          = listo_q;
    assign num_ops        = num_ops_q;

endmodule

// File: tb/tb_alu_secuenciador.sv
// Scoreboard bench for alu_secuenciador with a behavioural 3-bit ALU attached to its bus.
module tb_alu_secuenciador;
    localparam int N  = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  dato;
    logic [3:0]    sel_in;
    logic          flagin_in;
    logic          cargar;
    logic [N-1:0]  resultado_reg;
    logic [3:0]    flags_reg;
    logic [2:0]    estado;
    logic          listo;
    logic [CW-1:0] num_ops;

    int total = 0;
    int bad   = 0;

    alu_secuenciador_if #(.N(N)) bus ();

    alu_secuenciador #(.N(N), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .dato         (dato),
        .sel_in       (sel_in),
        .flagin_in    (flagin_in),
        .cargar       (cargar),
        .alu          (bus),
        .resultado_reg(resultado_reg),
        .flags_reg    (flags_reg),
        .estado       (estado),
        .listo        (listo),
        .num_ops      (num_ops)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {result[2:0], neg, zero, cout, ovf}.
    function automatic logic [6:0] alu_ref(input logic [2:0] a, input logic [2:0] b,
                                           input logic [3:0] s, input logic fi);
        int ia, ib, r;
        logic neg, c, v;
        logic [2:0] res;
        ia = int'(a); ib = int'(b);
        neg = 1'b0; c = 1'b0; v = 1'b0;
        case (s)
            4'd0: begin r = ia + ib; c = (r > 7); v = c; end
            4'd1: begin r = ia - ib; neg = (ia < ib); end
            4'd2: r = int'(a & b);
            4'd3: r = int'(a | b);
            4'd4: r = int'(a ^ b);
            4'd5: begin
                r = fi ? ia - 1 : ia + 1;
                c = fi ? (ia == 0) : (ia == 7);
                v = c;
            end
            4'd6: r = int'(~a);
            default: r = ia;
        endcase
        res = r[2:0];
        return {res, neg, (res == 3'd0), c, v};
    endfunction

    always_comb begin
        logic [6:0] o;
        o = alu_ref(bus.alu_A, bus.alu_B, bus.alu_select, bus.alu_flagin);
        bus.alu_resultado = o[6:4];
        bus.alu_neg       = o[3];
        bus.alu_zero      = o[2];
        bus.alu_cout      = o[1];
        bus.alu_ovf       = o[0];
    end

    typedef struct {
        logic [2:0] res;
        logic [3:0] flags;
        logic [7:0] ops;
        logic [2:0] a;
        logic [2:0] b;
    } exp_t;

    exp_t sbq[$];

    // High-level model state
    logic       showing = 1'b0;
    logic [2:0] m_res   = '0;
    int         m_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: each rising listo is one finished operation.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (listo === 1'b1 && prev === 1'b0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 32'(resultado_reg), 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("result",  32'(resultado_reg), 32'(e.res));
                    chk("flags",   32'(flags_reg),     32'(e.flags));
                    chk("num_ops", 32'(num_ops),       32'(e.ops));
                    chk("op_A",    32'(bus.alu_A),     32'(e.a));
                    chk("op_B",    32'(bus.alu_B),     32'(e.b));
                    chk("estado_show", 32'(estado),    32'd4);
                end
            end
            prev = listo;
        end
    end

    task automatic strobe(input logic [2:0] d, input logic [3:0] s, input logic fi);
        @(negedge clk);
        dato = d; sel_in = s; flagin_in = fi; cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        showing = 1'b0; m_res = '0; m_cnt = 0;
    endtask

    // Loads operands, accounting for how MUESTRA is left; returns the A the ALU will see.
    task automatic load_ab(input logic [2:0] a, input logic [2:0] b, output logic [2:0] ea);
        if (showing) begin
            strobe(3'($urandom), 4'($urandom), 1'($urandom));
`ifdef ALU_ACUM_EN
            ea = m_res;
`else
            strobe(a, 4'($urandom), 1'($urandom));
            ea = a;
`endif
        end else begin
            strobe(a, 4'($urandom), 1'($urandom));
            ea = a;
        end
        strobe(b, 4'($urandom), 1'($urandom));
    endtask

    task automatic expect_op(input logic [2:0] ea, input logic [2:0] b,
                             input logic [3:0] s, input logic fi);
        logic [6:0] r;
        exp_t e;
        r = alu_ref(ea, b, s, fi);
        m_cnt = (m_cnt + 1) % 256;
        m_res = r[6:4];
        e.res = r[6:4]; e.flags = r[3:0]; e.ops = 8'(m_cnt); e.a = ea; e.b = b;
        sbq.push_back(e);
        showing = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(sbq.size()), 32'd0);
    endtask

    task automatic do_op(input logic [2:0] a, input logic [2:0] b,
                         input logic [3:0] s, input logic fi);
        logic [2:0] ea;
        load_ab(a, b, ea);
        expect_op(ea, b, s, fi);
        strobe(3'($urandom), s, fi);
        drain();
    endtask

    initial begin
        logic [2:0] ea;
        rst = 1'b1; dato = '0; sel_in = '0; flagin_in = 1'b0; cargar = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_estado", 32'(estado), 32'd0);
        chk("idle_A", 32'(bus.alu_A), 32'd0);
        chk("idle_B", 32'(bus.alu_B), 32'd0);
        chk("idle_sel", 32'(bus.alu_select), 32'd0);
        chk("idle_flagin", 32'(bus.alu_flagin), 32'd0);
        chk("idle_result", 32'(resultado_reg), 32'd0);
        chk("idle_flags", 32'(flags_reg), 32'd0);
        chk("idle_listo", 32'(listo), 32'd0);
        chk("idle_num_ops", 32'(num_ops), 32'd0);

        do_op(3'd3, 3'd2, 4'd0, 1'b0);
        chk("first_result", 32'(resultado_reg), 32'd5);
        chk("first_flags", 32'(flags_reg), 32'd0);
        chk("first_listo", 32'(listo), 32'd1);
        chk("first_num_ops", 32'(num_ops), 32'd1);
        do_op(3'd5, 3'd4, 4'd0, 1'b0);
        do_op(3'd5, 3'd5, 4'd1, 1'b0);

        // cargar held through the capture edge and the EXEC edge
        load_ab(3'd6, 3'd3, ea);
        expect_op(ea, 3'd3, 4'd4, 1'b0);
        @(negedge clk);
        sel_in = 4'd4; flagin_in = 1'b0; cargar = 1'b1;
        repeat (2) @(negedge clk);
        cargar = 1'b0;
        drain();
        chk("hold_estado", 32'(estado), 32'd4);

        for (int i = 0; i < 20; i++)
            do_op(3'($urandom), 3'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));

        // asynchronous reset while in EXEC
        load_ab(3'd7, 3'd7, ea);
        @(negedge clk);
        sel_in = 4'd0; cargar = 1'b1;
        @(posedge clk);
        #1 cargar = 1'b0;
        chk("pre_rst_estado", 32'(estado), 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("rst_estado", 32'(estado), 32'd0);
        chk("rst_A", 32'(bus.alu_A), 32'd0);
        chk("rst_B", 32'(bus.alu_B), 32'd0);
        chk("rst_num_ops", 32'(num_ops), 32'd0);
        chk("rst_listo", 32'(listo), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        showing = 1'b0; m_res = '0; m_cnt = 0;
        @(negedge clk);
        chk("rst_result_kept0", 32'(resultado_reg), 32'd0);
        chk("rst_flags_kept0", 32'(flags_reg), 32'd0);

        for (int i = 0; i < 256; i++)
            do_op(3'($urandom), 3'($urandom), 4'($urandom_range(0, 6)), 1'($urandom));
        chk("wrap_num_ops", 32'(num_ops), 32'd0);

        do_reset();
        do_op(3'd2, 3'd1, 4'd0, 1'b0);
        strobe(3'd6, 4'd0, 1'b0);
`ifdef ALU_ACUM_EN
        chk("acum_A", 32'(bus.alu_A), 32'd3);
        chk("acum_estado", 32'(estado), 32'd1);
`else
        chk("noacum_A", 32'(bus.alu_A), 32'd2);
        chk("noacum_estado", 32'(estado), 32'd0);
`endif
        chk("leave_listo", 32'(listo), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running required finished");
        $fatal(1);
    end
endmodule
